// File: rtl/chunked_cla_adder.sv
// Multi-cycle N-bit adder: sum = a + b + cin.
// One CHUNK-bit carry-lookahead slice is resolved per clock, least-significant
// slice first. The carry between slices is kept in a register, so the critical
// path is a single CHUNK-bit lookahead rather than a full-width one.
// Operands arrive on a valid/ready handshake and results leave on another.
module chunked_cla_adder #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow,
  output logic         busy
);

  localparam int NC = N / CHUNK;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next_state;

  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic           r_carry;
  logic [IW-1:0]  r_idx;
  logic [N-1:0]   r_sum;
  logic           r_cout;
  logic           r_overflow;

  logic           w_accept;
  logic           w_last;
  logic [CHUNK-1:0] w_a_s;
  logic [CHUNK-1:0] w_b_s;
  logic [CHUNK-1:0] w_g;
  logic [CHUNK-1:0] w_p;
  logic [CHUNK:0]   w_carry;
  logic [CHUNK-1:0] w_slice_sum;

  // Operands are taken only on an edge where both sides agree.
  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_idx == IW'(NC - 1));

  // Select the slice under work and form generate/propagate terms.
  assign w_a_s = r_a[r_idx*CHUNK +: CHUNK];
  assign w_b_s = r_b[r_idx*CHUNK +: CHUNK];
  assign w_g   = w_a_s & w_b_s;
  assign w_p   = w_a_s | w_b_s;

  // Lookahead carries: each carry is the OR of every generate term that can
  // reach it through an unbroken run of propagates, plus the incoming carry.
  always_comb begin
    logic acc;
    logic prop;
    // NOTE: every combinational output gets a default before any conditional
    // or looped assignment, so no path leaves it holding a value (no latch).
    w_carry    = '0;
    w_carry[0] = r_carry;
    for (int i = 0; i < CHUNK; i++) begin
      acc  = 1'b0;
      prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc  = acc | (prop & w_g[j]);
        prop = prop & w_p[j];
      end
      w_carry[i+1] = acc | (prop & r_carry);
    end
  end

  assign w_slice_sum = w_a_s ^ w_b_s ^ w_carry[CHUNK-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next_state = S_BUSY;
      S_BUSY: if (w_last)   w_next_state = S_DONE;
      S_DONE: begin
        if (out_ready) w_next_state = in_valid ? S_BUSY : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    out_valid = (r_state == S_DONE);
    busy      = (r_state == S_BUSY);
  end

  // Operand capture and per-slice accumulation of the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == S_BUSY) begin
      r_sum[r_idx*CHUNK +: CHUNK] <= w_slice_sum;
      r_carry                     <= w_carry[CHUNK];
      r_idx                       <= r_idx + 1'b1;
      if (w_last) begin
        // The last slice holds bit N-1, so its top sum bit is the sign.
        r_cout     <= w_carry[CHUNK];
        r_overflow <= (r_a[N-1] == r_b[N-1]) && (w_slice_sum[CHUNK-1] != r_a[N-1]);
      end
    end
  end

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_chunked_cla_adder.sv
// Testbench for chunked_cla_adder at N=8, CHUNK=4 (two compute cycles).
// Expected results come from plain integer arithmetic on the operands.
module tb_chunked_cla_adder;

  localparam int N     = 8;
  localparam int CHUNK = 4;
  localparam int NC    = N / CHUNK;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  chunked_cla_adder #(.N(N), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; drive and sample 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned sum with carry, signed overflow by range check.
  task automatic ref_add(input logic [N-1:0] ra, input logic [N-1:0] rb, input logic rc,
                         output logic [N-1:0] rs, output logic rco, output logic rov);
    int u, sa, sb, ss;
    u   = int'(ra) + int'(rb) + int'(rc);
    rs  = N'(u % (1 << N));
    rco = (u >= (1 << N));
    sa  = ra[N-1] ? int'(ra) - (1 << N) : int'(ra);
    sb  = rb[N-1] ? int'(rb) - (1 << N) : int'(rb);
    ss  = sa + sb + int'(rc);
    rov = (ss > (1 << (N-1)) - 1) || (ss < -(1 << (N-1)));
  endtask

  // Present operands, wait for the result, check latency and values.
  // leave_done=1 returns with the result still held in DONE.
  task automatic do_op(input string tag, input logic [N-1:0] oa, input logic [N-1:0] ob,
                       input logic oc, input bit leave_done);
    logic [N-1:0] es;
    logic eco, eov;
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin tick(); cyc++; end
    if (!in_ready) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    ref_add(oa, ob, oc, es, eco, eov);
    in_valid = 1'b1; a = oa; b = ob; cin = oc;
    tick();
    in_valid = 1'b0;
    a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 20) begin tick(); cyc++; end
    check({tag, "_latency"},  32'(cyc), 32'(NC));
    check({tag, "_sum"},      32'(sum), 32'(es));
    check({tag, "_cout"},     32'(cout), 32'(eco));
    check({tag, "_overflow"}, 32'(overflow), 32'(eov));
    if (!leave_done) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    logic rc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #12;
    check("rst_sum",       32'(sum), 32'd0);
    check("rst_cout",      32'(cout), 32'd0);
    check("rst_overflow",  32'(overflow), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready",  32'(in_ready), 32'd1);

    // Directed cases.
    do_op("pos_ovf",     8'h7F, 8'h01, 1'b0, 1'b0);
    do_op("wrap",        8'hFF, 8'h01, 1'b0, 1'b0);
    do_op("chunk_carry", 8'h0F, 8'h00, 1'b1, 1'b0);
    do_op("neg_ovf",     8'h80, 8'hFF, 1'b0, 1'b0);

    // Backpressure: result must hold while the consumer stalls.
    do_op("bp", 8'h12, 8'h34, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'hEE; b = 8'hEE; cin = 1'b1;
      #1;
      check("bp_in_ready",  32'(in_ready), 32'd0);
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum",       32'(sum), 32'h46);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_drop_valid", 32'(out_valid), 32'd0);
    check("bp_idle_sum",   32'(sum), 32'h46);

    // Back-to-back: new operands accepted in the DONE cycle.
    do_op("b2b_first", 8'h21, 8'h43, 1'b0, 1'b1);
    out_ready = 1'b1; in_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    tick();
    out_ready = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    check("b2b_busy",       32'(busy), 32'd1);
    check("b2b_valid_low0", 32'(out_valid), 32'd0);
    tick();
    check("b2b_valid_low1", 32'(out_valid), 32'd0);
    tick();
    check("b2b_valid",    32'(out_valid), 32'd1);
    check("b2b_sum",      32'(sum), 32'h00);
    check("b2b_cout",     32'(cout), 32'd1);
    check("b2b_overflow", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during the first compute cycle discards the operation.
    in_valid = 1'b1; a = 8'h99; b = 8'h77; cin = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum",   32'(sum), 32'd0);
    check("mid_rst_busy",  32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_rst_no_stale", 32'(out_valid), 32'd0);
    end

    // Randomized operations with random consumer stalls.
    for (int i = 0; i < 1000; i++) begin
      ra = N'($urandom); rb = N'($urandom); rc = 1'($urandom);
      do_op("rand", ra, rb, rc, 1'b1);
      for (int s = 0; s < int'($urandom_range(0, 2)); s++) tick();
      check("rand_hold_sum", 32'(sum), 32'((int'(ra) + int'(rb) + int'(rc)) % 256));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/chunked_cla_adder.md
Name: chunked_cla_adder

Overview:
- Multi-cycle N-bit adder: sum = a + b + cin.
- Processes one CHUNK-bit carry-lookahead slice per clock, least-significant slice first; the carry is registered between slices.
- It is the addition-side counterpart of the team's carry-lookahead subtractor. It targets datapaths where a full-width single-cycle CLA misses timing.
- Operands enter through a valid/ready input handshake. Results leave through a valid/ready output handshake.

Parameters:
- N, 32, operand and sum width; must be a multiple of CHUNK.
- CHUNK, 8, bits resolved per cycle by the internal CLA slice (generate g=a&b, propagate p=a|b).
- NC, N/CHUNK (derived localparam), number of compute cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  N  operand A (unsigned/two's complement).
- b  input  N  operand B.
- cin  input  1  carry in.
- out_valid  output  1  sum, cout, overflow are valid.
- out_ready  input  1  consumer accepts result this cycle.
- sum  output  N  a+b+cin modulo 2^N.
- cout  output  1  carry out of bit N-1.
- overflow  output  1  signed overflow: a[N-1]==b[N-1] and sum[N-1]!=a[N-1].
- busy  output  1  high in BUSY state.

Behaviour:
- Reset (async assert, sync deassert handled by the system):
  - state=IDLE.
  - sum=0, cout=0, overflow=0, out_valid=0, busy=0.
  - Internal operand registers, carry register and chunk index = 0.
  - in_ready=1 once rst_n is high.
- States:
  - IDLE: in_ready=1. On in_valid: latch a, b, cin into carry register; index=0; go to BUSY.
  - BUSY: each cycle compute slice [index*CHUNK +: CHUNK] with lookahead carries from the carry register. Write the slice into sum; update the carry register with the slice carry-out; index++. On the cycle index==NC-1: cout=slice carry; overflow computed per the port definition; go to DONE.
  - DONE: out_valid=1. Result holds stable while out_ready=0. On out_ready=1: result consumed.
- in_ready = (state==IDLE) or (state==DONE and out_ready). This gives back-to-back operation with no bubble beyond the compute cycles.
- DONE with out_ready=1 and in_valid=1 in the same cycle: the result is consumed and new operands are latched; next state BUSY.
- DONE with out_ready=1 and in_valid=0: next state IDLE; out_valid drops.
- Latency: operands accepted at clock edge k produce out_valid=1 after edge k+NC. Throughput is one result per NC+1 cycles with continuous handshakes.
- in_valid and operands are ignored when in_ready=0. Inputs are sampled only on an accepting edge, so later changes to a/b/cin do not disturb an operation in flight.
- sum is visible only when out_valid=1; it is don't-care (partially updated) during BUSY. sum, cout and overflow hold their last values in IDLE.
- NC==1: BUSY lasts exactly one cycle.
- Wrap-around: the carry out of bit N-1 goes to cout only, never into bit 0. All arithmetic is modulo 2^N.
- Reset mid-operation (any state): immediately return to the reset values above. The in-flight operation is discarded, with no out_valid pulse.

Test Plan:
- N=8, CHUNK=4; a=0x7F, b=0x01, cin=0 -> after 2 cycles out_valid=1, sum=0x80, cout=0, overflow=1.
- N=8, CHUNK=4; a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0.
- Inter-chunk carry: a=0x0F, b=0x00, cin=1 -> sum=0x10, cout=0, overflow=0. Confirms the registered carry crosses the slice boundary.
- Backpressure: result a=0x12, b=0x34 held with out_ready=0 for 5 cycles -> sum=0x46 stable; in_ready=0 throughout; in_valid pulses ignored. Then out_ready=1 -> out_valid drops next cycle.
- Back-to-back: second operand pair (0xAA+0x55, cin=1) presented in the DONE cycle with out_ready=1 -> accepted that edge. Next result sum=0x00, cout=1 arrives exactly 2 cycles later.
- Reset mid-BUSY: drop rst_n during cycle 1 of an operation -> out_valid=0, sum=0, in_ready=1 after release; no stale result is emitted. A randomized 1000-operation comparison against a+b+cin then passes.
